// File: rtl/uart_typedef_pkg.sv
// Shared UART types and constants for the receive and transmit paths.
package uart_typedef_pkg;

   localparam int UART_OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } uart_rx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: a reloadable down-counter that fires one tick every div clocks.
module uart_baud_gen #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_reg;
   logic [DIV_W-1:0] reload;

   // A divisor of 0 behaves like 1: tick every cycle.
   assign reload = (div == '0) ? '0 : div - DIV_W'(1);
   assign tick   = en & ~load & (cnt_reg == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= reload;
      end else if (en) begin
         cnt_reg <= (cnt_reg == '0) ? reload : cnt_reg - DIV_W'(1);
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes and oversamples rx_i, recovers start/data/parity/stop,
// and presents each word on a valid/ready handshake with error flags and overrun pulse.
module uart_rx
   import uart_typedef_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0,
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int DIV_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DIV_W-1:0]     cfg_div_i,
   input  logic                 rx_i,
   output logic                 rx_valid_o,
   input  logic                 rx_ready_i,
   output logic [DATA_BITS-1:0] rx_data_o,
   output logic                 rx_parity_err_o,
   output logic                 rx_frame_err_o,
   output logic                 rx_overrun_o,
   output logic                 rx_busy_o
);

   localparam int OS_W  = $clog2(OVERSAMPLE);
   localparam int BIT_W = $clog2(DATA_BITS);
   localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

   uart_rx_state_t       state_reg, state_next;
   logic                 rx_meta_reg, rxs_reg, rxs_prev_reg;
   logic [DIV_W-1:0]     div_reg;
   logic [OS_W-1:0]      os_cnt_reg;
   logic [BIT_W-1:0]     bit_cnt_reg;
   logic [DATA_BITS-1:0] shift_data_reg;
   logic                 par_calc_reg;
   logic [DATA_BITS-1:0] data_reg;
   logic                 par_err_reg, frame_err_reg, valid_reg, overrun_reg;

   logic             baud_tick, baud_load, sample, start_edge, deliver, accept_new;
   logic [DIV_W-1:0] baud_div;

   assign start_edge = rxs_prev_reg & ~rxs_reg;
   assign baud_load  = (state_reg == IDLE);
   // While idle the counter tracks the live divisor so the first tick of a frame uses the captured value.
   assign baud_div   = baud_load ? cfg_div_i : div_reg;
   assign sample     = baud_tick && (os_cnt_reg == OS_MID);
   assign deliver    = (state_reg == STOP) && sample;
   assign accept_new = deliver && (!valid_reg || rx_ready_i);

   uart_baud_gen #(
      .DIV_W(DIV_W)
   ) u_baud_gen (
      .clk  (clk),
      .rst  (rst),
      .load (baud_load),
      .en   (~baud_load),
      .div  (baud_div),
      .tick (baud_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:      if (start_edge) state_next = START;
         START:     if (sample) state_next = rxs_reg ? IDLE : DATA;
         DATA: begin
            if (sample && (bit_cnt_reg == BIT_LAST)) begin
               state_next = (PARITY_EN != 0) ? PARITY : STOP;
            end
         end
         PARITY:    if (sample) state_next = STOP;
         STOP:      if (sample) state_next = rxs_reg ? IDLE : WAIT_IDLE;
         WAIT_IDLE: if (rxs_reg) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_reg    <= 1'b1;
         rxs_reg        <= 1'b1;
         rxs_prev_reg   <= 1'b1;
         div_reg        <= '0;
         os_cnt_reg     <= '0;
         bit_cnt_reg    <= '0;
         shift_data_reg <= '0;
         par_calc_reg   <= 1'b0;
         data_reg       <= '0;
         par_err_reg    <= 1'b0;
         frame_err_reg  <= 1'b0;
         valid_reg      <= 1'b0;
         overrun_reg    <= 1'b0;
      end else begin
         rx_meta_reg  <= rx_i;
         rxs_reg      <= rx_meta_reg;
         rxs_prev_reg <= rxs_reg;
         overrun_reg  <= deliver && !accept_new;

         if (state_reg == IDLE) begin
            os_cnt_reg   <= '0;
            bit_cnt_reg  <= '0;
            par_calc_reg <= 1'b0;
            if (start_edge) div_reg <= cfg_div_i;
         end else if (baud_tick) begin
            os_cnt_reg <= (os_cnt_reg == OS_LAST) ? '0 : os_cnt_reg + OS_W'(1);
            if (sample) begin
               case (state_reg)
                  // Pin the phase so the next sample lands one full bit after mid-start.
                  START:  os_cnt_reg <= OS_W'(OVERSAMPLE / 2);
                  DATA: begin
                     shift_data_reg <= {rxs_reg, shift_data_reg[DATA_BITS-1:1]};
                     bit_cnt_reg    <= bit_cnt_reg + BIT_W'(1);
                  end
                  PARITY: par_calc_reg <= ((^shift_data_reg) ^ rxs_reg) != 1'(PARITY_ODD);
                  default: ;
               endcase
            end
         end

         if (accept_new) begin
            data_reg      <= shift_data_reg;
            par_err_reg   <= par_calc_reg;
            frame_err_reg <= ~rxs_reg;
            valid_reg     <= 1'b1;
         end else if (valid_reg && rx_ready_i) begin
            valid_reg <= 1'b0;
         end
      end
   end

   assign rx_valid_o      = valid_reg;
   assign rx_data_o       = data_reg;
   assign rx_parity_err_o = par_err_reg;
   assign rx_frame_err_o  = frame_err_reg;
   assign rx_overrun_o    = overrun_reg;
   assign rx_busy_o       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 8E1, OVERSAMPLE=16, cfg_div=4.
module tb_uart_rx;

   localparam int DIV     = 4;
   localparam int OS      = 16;
   localparam int BIT_CYC = DIV * OS;
   // 2 sync flops + edge register, half a bit to mid-start, then 10 more bit periods to mid-stop.
   localparam int LAT_CYC = 3 + DIV * (OS / 2) + 10 * BIT_CYC;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cfg_div = 16'(DIV);
   logic        rx_i = 1'b1;
   logic        rx_ready = 1'b0;
   logic        rx_valid, rx_perr, rx_ferr, rx_ovr, rx_busy;
   logic [7:0]  rx_data;

   int errors = 0, checks = 0;
   int cyc = 0, start_cyc = 0, rise_cyc = -1, rise_cnt = 0, ovr_cnt = 0;
   logic busy_seen = 1'b0, valid_prev = 1'b0;

   uart_rx dut (
      .clk             (clk),
      .rst             (rst),
      .cfg_div_i       (cfg_div),
      .rx_i            (rx_i),
      .rx_valid_o      (rx_valid),
      .rx_ready_i      (rx_ready),
      .rx_data_o       (rx_data),
      .rx_parity_err_o (rx_perr),
      .rx_frame_err_o  (rx_ferr),
      .rx_overrun_o    (rx_ovr),
      .rx_busy_o       (rx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_valid && !valid_prev) begin
         rise_cyc = cyc;
         rise_cnt++;
      end
      valid_prev = rx_valid;
      if (rx_ovr) ovr_cnt++;
      if (rx_busy) busy_seen = 1'b1;
   end

   task automatic drive_bit(input logic b);
      @(posedge clk);
      #1 rx_i = b;
      repeat (BIT_CYC - 1) @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
      rise_cyc = -1;
      @(posedge clk);
      #1 rx_i = 1'b0;
      start_cyc = cyc;
      repeat (BIT_CYC - 1) @(posedge clk);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(par);
      drive_bit(stp);
      @(negedge clk);
      $display("frame sent data=%02h par=%0b stop=%0b -> valid=%0b data=%02h perr=%0b ferr=%0b",
               d, par, stp, rx_valid, rx_data, rx_perr, rx_ferr);
   endtask

   task automatic accept_word();
      @(posedge clk);
      #1 rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", rx_valid); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%02h exp=00", rx_data); end
      checks++; if (rx_perr !== 1'b0 || rx_ferr !== 1'b0) begin errors++; $display("FAIL reset_flags got=%0b%0b exp=00", rx_perr, rx_ferr); end
      checks++; if (rx_ovr !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%0b exp=0", rx_ovr); end
      checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", rx_busy); end
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) @(posedge clk);
   endtask

   task automatic test_basic();
      send_frame(8'hA5, 1'b0, 1'b1);
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%0b exp=1", rx_valid); end
      checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL basic_data got=%02h exp=a5", rx_data); end
      checks++; if (rx_perr !== 1'b0 || rx_ferr !== 1'b0) begin errors++; $display("FAIL basic_flags got=%0b%0b exp=00", rx_perr, rx_ferr); end
      checks++; if (rise_cyc !== start_cyc + LAT_CYC) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", rise_cyc - start_cyc, LAT_CYC); end
      accept_word();
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_accept got=%0b exp=0", rx_valid); end
   endtask

   task automatic test_parity_err();
      send_frame(8'h3C, 1'b1, 1'b1);
      checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL parity_data got=%02h exp=3c", rx_data); end
      checks++; if (rx_perr !== 1'b1) begin errors++; $display("FAIL parity_perr got=%0b exp=1", rx_perr); end
      checks++; if (rx_ferr !== 1'b0) begin errors++; $display("FAIL parity_ferr got=%0b exp=0", rx_ferr); end
      accept_word();
   endtask

   task automatic test_break();
      int rises;
      send_frame(8'h00, 1'b0, 1'b0);
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL break_valid got=%0b exp=1", rx_valid); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL break_data got=%02h exp=00", rx_data); end
      checks++; if (rx_ferr !== 1'b1 || rx_perr !== 1'b0) begin errors++; $display("FAIL break_flags perr/ferr got=%0b%0b exp=01", rx_perr, rx_ferr); end
      accept_word();
      rises = rise_cnt;
      repeat (2 * BIT_CYC) @(posedge clk);
      @(negedge clk);
      checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL break_hold_busy got=%0b exp=1", rx_busy); end
      checks++; if (rx_valid !== 1'b0 || rise_cnt !== rises) begin errors++; $display("FAIL break_no_second valid=%0b rises=%0d exp 0/%0d", rx_valid, rise_cnt, rises); end
      @(posedge clk);
      #1 rx_i = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL break_release_busy got=%0b exp=0", rx_busy); end
      repeat (BIT_CYC) @(posedge clk);
   endtask

   task automatic test_glitch();
      int rises;
      rises = rise_cnt;
      busy_seen = 1'b0;
      @(posedge clk);
      #1 rx_i = 1'b0;
      repeat (3 * DIV) @(posedge clk);
      #1 rx_i = 1'b1;
      repeat (BIT_CYC) @(posedge clk);
      @(negedge clk);
      $display("glitch 3 ticks -> busy_seen=%0b busy=%0b valid=%0b", busy_seen, rx_busy, rx_valid);
      checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_pulse got=%0b exp=1", busy_seen); end
      checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got=%0b exp=0", rx_busy); end
      checks++; if (rx_valid !== 1'b0 || rise_cnt !== rises) begin errors++; $display("FAIL glitch_no_word valid=%0b rises=%0d exp 0/%0d", rx_valid, rise_cnt, rises); end
   endtask

   task automatic test_back_to_back();
      int ovr0, rises;
      rx_ready = 1'b0;
      ovr0 = ovr_cnt;
      send_frame(8'h11, 1'b0, 1'b1);
      rises = rise_cnt;
      checks++; if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_first data=%02h valid=%0b exp 11/1", rx_data, rx_valid); end
      checks++; if (ovr_cnt !== ovr0) begin errors++; $display("FAIL b2b_no_early_overrun got=%0d exp=%0d", ovr_cnt - ovr0, 0); end
      send_frame(8'h22, 1'b0, 1'b1);
      checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL b2b_held_data got=%02h exp=11", rx_data); end
      checks++; if (rx_valid !== 1'b1 || rise_cnt !== rises) begin errors++; $display("FAIL b2b_held_valid valid=%0b rises=%0d exp 1/%0d", rx_valid, rise_cnt, rises); end
      checks++; if (ovr_cnt !== ovr0 + 1) begin errors++; $display("FAIL b2b_overrun_pulses got=%0d exp=1", ovr_cnt - ovr0); end
      accept_word();
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_accept got=%0b exp=0", rx_valid); end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] d;
      int rises;
      d = 8'h5A;
      @(posedge clk);
      #1 rx_i = 1'b0;
      repeat (BIT_CYC - 1) @(posedge clk);
      for (int i = 0; i < 4; i++) drive_bit(d[i]);
      @(posedge clk);
      #1 rx_i = d[4];
      repeat (BIT_CYC / 2) @(posedge clk);
      @(negedge clk);
      checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got=%0b exp=1", rx_busy); end
      #1 rst = 1'b1;
      rx_i = 1'b1;
      #1;
      checks++; if (rx_busy !== 1'b0 || rx_valid !== 1'b0 || rx_ovr !== 1'b0) begin errors++; $display("FAIL rstmid_outputs busy=%0b valid=%0b ovr=%0b exp 000", rx_busy, rx_valid, rx_ovr); end
      checks++; if (rx_data !== 8'h00 || rx_perr !== 1'b0 || rx_ferr !== 1'b0) begin errors++; $display("FAIL rstmid_data data=%02h flags=%0b%0b exp 00/00", rx_data, rx_perr, rx_ferr); end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (BIT_CYC) @(posedge clk);
      rises = rise_cnt;
      send_frame(8'h81, 1'b0, 1'b1);
      checks++; if (rx_data !== 8'h81 || rx_valid !== 1'b1) begin errors++; $display("FAIL rstmid_data_after data=%02h valid=%0b exp 81/1", rx_data, rx_valid); end
      checks++; if (rx_perr !== 1'b0 || rx_ferr !== 1'b0) begin errors++; $display("FAIL rstmid_flags got=%0b%0b exp=00", rx_perr, rx_ferr); end
      checks++; if (rise_cnt !== rises + 1) begin errors++; $display("FAIL rstmid_word_count got=%0d exp=1", rise_cnt - rises); end
      checks++; if (rise_cyc !== start_cyc + LAT_CYC) begin errors++; $display("FAIL rstmid_latency got=%0d exp=%0d", rise_cyc - start_cyc, LAT_CYC); end
      accept_word();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity_err();
      test_break();
      test_glitch();
      test_back_to_back();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive-side deserializer for the UART link: the DUT-side counterpart to the UART transmit path that drives the serial line.
- Synchronizes and oversamples the asynchronous rx line, then recovers start/data/parity/stop.
- Presents each byte on a valid/ready handshake, with per-frame parity and framing error flags and an overrun pulse.
- Sits between the pad and the command/response parser.

Parameters:
- DATA_BITS, 8, number of data bits per frame, 5..9, LSB first.
- PARITY_EN, 1, 1 = parity bit present after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- OVERSAMPLE, 16, ticks per bit; must be even, >= 8.
- DIV_W, 16, width of the baud divisor input.

Ports:
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_div_i  in  DIV_W  clk cycles per oversample tick; 0 is treated as 1.
- rx_i  in  1  asynchronous serial line; idle high.
- rx_valid_o  out  1  received word available.
- rx_ready_i  in  1  consumer accepts the word.
- rx_data_o  out  DATA_BITS  received data.
- rx_parity_err_o  out  1  parity mismatch for the held word; qualified by rx_valid_o.
- rx_frame_err_o  out  1  stop bit sampled low for the held word; qualified by rx_valid_o.
- rx_overrun_o  out  1  one-cycle pulse when a completed frame is dropped.
- rx_busy_o  out  1  high from start-bit detect until return to IDLE.

Behaviour:
- Reset values: rx_valid_o=0, rx_data_o=0, both error flags 0, rx_overrun_o=0, rx_busy_o=0; state IDLE; synchronizer flops =1; all counters 0.
- Reset mid-frame aborts the frame; no word is emitted.
- Input path: 2-flop synchronizer on rx_i; all decisions use the second-stage output (rxs).
- Baud tick:
  - Divisor counter reloads with cfg_div_i-1 and emits a 1-cycle tick at 0.
  - cfg_div_i is captured at start-bit detect and held constant for the frame.
  - The counter is held at reload in IDLE.
- os_cnt counts ticks 0..OVERSAMPLE-1 within each bit. A bit is sampled when os_cnt==OVERSAMPLE/2-1 (mid-bit), single sample.
- State machine:
  - IDLE: on rxs 1->0, go to START and clear os_cnt; rx_busy_o=1.
  - START: at the mid-bit sample, rxs=1 means false start -> IDLE, nothing emitted. rxs=0 means re-align os_cnt so later samples land mid-bit, then DATA.
  - DATA: shift in DATA_BITS samples LSB first, one per bit period. After the last bit go to PARITY, or to STOP when PARITY_EN=0.
  - PARITY: sample the bit. Error if (XOR of data ^ parity bit) != PARITY_ODD.
  - STOP: sample the bit; frame_err = ~rxs.
    - Deliver the word (see below) in the same cycle as the sample.
    - rxs=1: go to IDLE.
    - rxs=0 (framing error or break): go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxs=1, then IDLE. No new start is recognized here.
- Delivery at stop sample:
  - rx_valid_o=0, or rx_ready_i=1 in the same cycle: load data and flags; rx_valid_o=1 next cycle.
  - Otherwise: keep the held word and flags, drop the new frame, pulse rx_overrun_o for 1 cycle.
- Handshake:
  - rx_valid_o stays high until rx_valid_o & rx_ready_i.
  - Data and flags are stable while rx_valid_o=1.
  - Simultaneous accept and new load: the new word replaces the old one, rx_valid_o stays 1, no overrun.
- Latency: rx_valid_o rises 1 clk after the stop-bit mid-sample tick.
- rx_ready_i while rx_valid_o=0 has no effect.

Decomposition:
- Shared package uart_typedef_pkg gains:
  - uart_rx_state_t enum {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE}.
  - UART_OVERSAMPLE constant, default 16.
- Sub-module uart_baud_gen: divisor counter plus tick output, with load/enable inputs. It is reused by the TX path.

Test Plan:
- cfg_div=4, OVERSAMPLE=16, 8E1, send 0xA5 (parity 0), stop 1 -> rx_data_o=0xA5, both error flags 0; rx_valid_o rises 1 clk after the stop mid-sample.
- Send 0x3C with parity bit 1 (wrong for even) -> rx_data_o=0x3C, rx_parity_err_o=1, rx_frame_err_o=0.
- Send 0x00 with rx held low 3 bit-times past stop (break) -> rx_frame_err_o=1, data 0x00, no second frame until rx returns high.
- Low glitch lasting 3 ticks on idle line -> rx_busy_o pulses, returns to IDLE, rx_valid_o stays 0.
- rx_ready_i=0, two back-to-back frames 0x11 then 0x22:
  - rx_data_o stays 0x11.
  - rx_overrun_o pulses once at the second stop sample.
  - Then rx_ready_i=1 -> rx_valid_o falls next cycle.
- Assert rst during DATA bit 4 of 0x5A, release, then send 0x81 -> only 0x81 delivered, no errors, all outputs at reset values during rst.
